// File: rtl/myproject_mul_pkg.sv
// Shared widths, stage limits and the round/saturate helper used by the MHA rescalers.
// Consumed by myproject_mul_pipe_ss; sat_rnd is only referenced when MYPROJECT_MUL_SAT_EN is defined.
package myproject_mul_pkg;

    localparam int MUL_MIN_STAGE = 1;
    localparam int MUL_MAX_STAGE = 4;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic int mul_full_w(input int a, input int b);
        return a + b;
    endfunction

    // Round half toward +inf, then clamp to a signed field of 'width' bits.
    function automatic sat_res_t sat_rnd(input logic signed [63:0] p, input int shift, input int width);
        sat_res_t           res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = p;
        if (shift > 0) begin
            r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        res.sat = (r > hi) || (r < lo);
        res.val = (r > hi) ? hi : ((r < lo) ? lo : r);
        return res;
    endfunction

endpackage

// File: rtl/myproject_mul_pipe_stage.sv
// One {valid, data} pipeline slot. It loads when empty or when the slot downstream loads,
// so bubbles collapse and a stalled slot keeps its data.
module myproject_mul_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          down_load_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          load_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    assign load_o = !valid_q || down_load_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/myproject_mul_pipe_ss.sv
// Pipelined signed x signed multiplier with valid/ready flow control, NUM_STAGE slots deep.
// Define MYPROJECT_MUL_SAT_EN to round/saturate into dout_WIDTH and expose the sticky sat_flag.
module myproject_mul_pipe_ss
    import myproject_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 26,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
`ifdef MYPROJECT_MUL_SAT_EN
    output logic                  sat_flag,
`endif
    output logic                  busy
);

    localparam int FW  = mul_full_w(din0_WIDTH, din1_WIDTH);
    localparam int MID = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    if (NUM_STAGE < MUL_MIN_STAGE || NUM_STAGE > MUL_MAX_STAGE) begin : g_bad_stage
        $error("myproject_mul_pipe_ss: NUM_STAGE out of range");
    end
`ifndef MYPROJECT_MUL_SAT_EN
    if (dout_WIDTH != FW) begin : g_bad_width
        $error("myproject_mul_pipe_ss: dout_WIDTH must equal din0_WIDTH+din1_WIDTH");
    end
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready is a function of downstream ready and the slot valids only, never of valid.
    logic [NUM_STAGE:1]   v;
    logic [NUM_STAGE+1:1] ld;
    logic [FW-1:0]        mid_q [1:MID];
    logic signed [FW-1:0] mul_a;
    logic signed [FW-1:0] mul_b;
    logic signed [FW-1:0] p_full;
    logic                 last_v_in;
    logic [FW-1:0]        last_pre;
    logic [dout_WIDTH-1:0] fin;

    assign ld[NUM_STAGE+1] = out_ready;

    if (NUM_STAGE == 1) begin : g_mul_in
        assign mul_a = FW'($signed(din0));
        assign mul_b = FW'($signed(din1));
    end else begin : g_mul_reg
        assign mul_a = FW'($signed(mid_q[1][FW-1 -: din0_WIDTH]));
        assign mul_b = FW'($signed(mid_q[1][din1_WIDTH-1:0]));
    end
    assign p_full = mul_a * mul_b;

    for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_stage
        logic          v_in;
        logic [FW-1:0] d_in;
        if (k == 1) begin : g_first
            assign v_in = in_valid;
            assign d_in = (NUM_STAGE == 1) ? p_full : {din0, din1};
        end else if (k == 2) begin : g_prod
            assign v_in = v[1];
            assign d_in = p_full;
        end else begin : g_delay
            assign v_in = v[k-1];
            assign d_in = mid_q[k-1];
        end

        if (k < NUM_STAGE) begin : g_mid
            myproject_mul_pipe_stage #(.DW(FW)) u_stage (
                .clk_i       (ap_clk),
                .rst_ni      (ap_rst_n),
                .valid_i     (v_in),
                .data_i      (d_in),
                .down_load_i (ld[k+1]),
                .valid_o     (v[k]),
                .data_o      (mid_q[k]),
                .load_o      (ld[k])
            );
        end else begin : g_last
            myproject_mul_pipe_stage #(.DW(dout_WIDTH)) u_stage (
                .clk_i       (ap_clk),
                .rst_ni      (ap_rst_n),
                .valid_i     (v_in),
                .data_i      (fin),
                .down_load_i (ld[k+1]),
                .valid_o     (v[k]),
                .data_o      (dout),
                .load_o      (ld[k])
            );
            assign last_v_in = v_in;
            assign last_pre  = d_in;
        end
    end

`ifdef MYPROJECT_MUL_SAT_EN
    sat_res_t sat_res;
    logic     sat_q;
    logic     sat_d;

    always_comb begin
        sat_res = sat_rnd(64'($signed(last_pre)), OUT_SHIFT, dout_WIDTH);
        fin     = sat_res.val[dout_WIDTH-1:0];
        sat_d   = sat_q || (ld[NUM_STAGE] && last_v_in && sat_res.sat);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_last_v;
    assign unused_last_v = last_v_in;
    assign fin = last_pre;
`endif

    assign in_ready  = ld[1];
    assign out_valid = v[NUM_STAGE];
    assign busy      = |v;

endmodule

// File: tb/tb_myproject_mul_pipe_ss.sv
// Randomised and directed stimulus against an arithmetic reference model and an expected queue.
// Build with MYPROJECT_MUL_SAT_EN defined to exercise the round/saturate variant.
module tb_myproject_mul_pipe_ss;

    localparam int NS = 3;
    localparam int AW = 16;
    localparam int BW = 10;
`ifdef MYPROJECT_MUL_SAT_EN
    localparam int DW  = 16;
    localparam int OSH = 4;
`else
    localparam int DW  = 26;
    localparam int OSH = 0;
`endif

    logic          ap_clk;
    logic          ap_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] din0;
    logic [BW-1:0] din1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic          busy;
`ifdef MYPROJECT_MUL_SAT_EN
    logic          sat_flag;
`endif

    myproject_mul_pipe_ss #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(AW), .din1_WIDTH(BW), .dout_WIDTH(DW), .OUT_SHIFT(OSH)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
`ifdef MYPROJECT_MUL_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    // clock / reset
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    int            cyc_q[$];
    int            n_checks = 0;
    int            n_err    = 0;
    int            cyc      = 0;
    int            outs     = 0;
    int            fires    = 0;
    int            ghost    = 0;
    int            ir_low   = 0;
    bit            chk_lat  = 0;
    bit            exp_sat  = 0;
    bit            held_v   = 0;
    logic [DW-1:0] held_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference: exact product, or floor((p + 2^(s-1)) / 2^s) clamped to DW signed bits.
    task automatic model(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                         output logic [DW-1:0] e, output bit clamp);
        longint p;
        longint q;
        p     = longint'(a) * longint'(b);
        q     = p;
        clamp = 0;
`ifdef MYPROJECT_MUL_SAT_EN
        begin
            longint d;
            longint num;
            longint lim;
            if (OSH > 0) begin
                d   = longint'(1) << OSH;
                num = p + d / 2;
                q   = num / d;
                if ((num % d != 0) && (num < 0)) q = q - 1;
            end
            lim = longint'(1) << (DW - 1);
            if (q > lim - 1) begin
                q = lim - 1;
                clamp = 1;
            end else if (q < -lim) begin
                q = -lim;
                clamp = 1;
            end
        end
`endif
        e = DW'(q);
    endtask

    // driver + monitor for one clock: drive, let combinational paths settle, record what fires
    task automatic cycle(input bit iv, input logic [AW-1:0] a, input logic [BW-1:0] b, input bit ordy);
        logic [DW-1:0] e;
        bit            cl;
        int            c;
        in_valid  = iv;
        din0      = a;
        din1      = b;
        out_ready = ordy;
        #1;
        if (!in_ready) ir_low++;
        if (held_v) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", dout, held_d);
        end
        if (out_valid && out_ready) begin
            outs++;
            if (exp_q.size() == 0) begin
                ghost++;
            end else begin
                check("dout", dout, exp_q.pop_front());
                c = cyc_q.pop_front();
                if (chk_lat) check("latency", 64'(cyc - c), 64'(NS));
            end
        end
        if (in_valid && in_ready) begin
            model(a, b, e, cl);
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
            fires++;
            if (cl) exp_sat = 1;
        end
        held_v = out_valid && !out_ready;
        held_d = dout;
        @(negedge ap_clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            cycle(0, '0, '0, 1);
        end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic rand_ops(output logic [AW-1:0] a, output logic [BW-1:0] b);
        a = ($urandom_range(0, 7) == 0) ? {1'b1, {(AW-1){1'b0}}} : AW'($urandom);
        b = ($urandom_range(0, 7) == 0) ? {1'b1, {(BW-1){1'b0}}} : BW'($urandom);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        int            start;
        int            t;

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (2) @(negedge ap_clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_busy", busy, 1'b0);
        ap_rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge ap_clk);

        // extremes with exact-latency check
        chk_lat = 1;
        cycle(1, 16'h8000, 10'h200, 1);
        cycle(1, 16'h7fff, 10'h1ff, 1);
        start = outs;
        drain();
        check("t1_outs", 64'(outs - start), 2);

        // stall mid-stream: 8 items, out_ready low for 5 cycles
        chk_lat = 0;
        ir_low  = 0;
        start   = fires;
        t       = 0;
        while ((fires - start) < 8 && t < 40) begin
            rand_ops(a, b);
            cycle(1, a, b, !(t >= 3 && t < 8));
            t++;
        end
        check("t2_accepted", 64'(fires - start), 8);
        check("t2_in_ready_drop", 64'(ir_low > 0), 1);
        drain();

        // sustained full-rate streaming
        chk_lat = 1;
        ir_low  = 0;
        start   = outs;
        for (int i = 0; i < NS + 20; i++) begin
            rand_ops(a, b);
            cycle(1, a, b, 1);
        end
        check("t3_outs", 64'(outs - start), 20);
        check("t3_in_ready_low", 64'(ir_low), 0);
        drain();

        // asynchronous reset with two items in flight
        for (int i = 0; i < 2; i++) begin
            rand_ops(a, b);
            cycle(1, a, b, 1);
        end
        in_valid = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("t4_out_valid", out_valid, 1'b0);
        check("t4_dout", dout, '0);
        check("t4_busy", busy, 1'b0);
`ifdef MYPROJECT_MUL_SAT_EN
        check("t4_sat_flag", sat_flag, 1'b0);
`endif
        exp_q.delete();
        cyc_q.delete();
        held_v  = 0;
        exp_sat = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check("t4_in_ready", in_ready, 1'b1);
        @(negedge ap_clk);
        start = ghost;
        repeat (8) cycle(0, '0, '0, 1);
        check("t4_no_ghost", 64'(ghost - start), 0);

`ifdef MYPROJECT_MUL_SAT_EN
        // rounding corner cases, including the exact half
        cycle(1, 16'd3, 10'd3, 1);
        cycle(1, 16'd7, 10'd1, 1);
        cycle(1, 16'hfffd, 10'd3, 1);
        cycle(1, 16'd1, 10'd8, 1);
        drain();
`endif

        // randomised traffic with random backpressure
        chk_lat = 0;
        for (int i = 0; i < 300; i++) begin
            rand_ops(a, b);
            cycle($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0);
        end
        drain();
`ifdef MYPROJECT_MUL_SAT_EN
        check("sat_flag", sat_flag, exp_sat);
`endif
        check("ghost_total", 64'(ghost), 0);
        check("idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
